// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx byte transmitter among N_REQ requesters
// Optional WAIT watchdog abort enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               I_CLK,
  input  logic               I_RSTF,
  input  logic [N_REQ-1:0]   I_REQ,
  input  logic [8*N_REQ-1:0] I_DATA,
  output logic [N_REQ-1:0]   O_GNT,
  output logic               O_TX_START,
  output logic [7:0]         O_TX_DATA,
  input  logic               I_TX_DONE,
  output logic               O_BUSY,
  output logic [3:0]         O_OWNER,
  output logic               O_TIMEOUT
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state;
  logic [3:0]       ptr;
  logic [15:0]      req_pad;
  logic [7:0]       data_arr [16];
  logic [3:0]       win;
  logic             found;
  logic [4:0]       idx;
  logic [N_REQ-1:0] win_onehot;
  logic             done_ok;
  logic             wd_hit;

  assign req_pad = 16'(I_REQ);

  for (genvar g = 0; g < 16; g++) begin : g_data
    if (g < N_REQ) begin : g_used
      assign data_arr[g] = I_DATA[8*g +: 8];
    end else begin : g_pad
      assign data_arr[g] = 8'h00;
    end
  end

  // Scan ptr+1, ptr+2, ... (mod N_REQ); the first set request wins.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = 5'(ptr) + 5'd1 + 5'(k);
      if (idx >= 5'(N_REQ)) idx = idx - 5'(N_REQ);
      if (!found && req_pad[idx[3:0]]) begin
        found = 1'b1;
        win   = idx[3:0];
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int j = 0; j < N_REQ; j++) win_onehot[j] = (win == 4'(j));
  end

  // A done seen while START is still high belongs to a previous transfer.
  assign done_ok = I_TX_DONE && !O_TX_START;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign wd_hit = (wd_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) begin
      wd_cnt <= '0;
    end else if (state == IDLE) begin
      wd_cnt <= '0;
    end else if (!wd_hit) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge I_CLK or negedge I_RSTF) begin
    if (!I_RSTF) begin
      state      <= IDLE;
      ptr        <= 4'(N_REQ - 1);
      O_GNT      <= '0;
      O_TX_START <= 1'b0;
      O_TX_DATA  <= 8'h00;
      O_BUSY     <= 1'b0;
      O_OWNER    <= 4'd0;
      O_TIMEOUT  <= 1'b0;
    end else begin
      O_GNT      <= '0;
      O_TX_START <= 1'b0;
      O_TIMEOUT  <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            O_TX_DATA  <= data_arr[win];
            O_GNT      <= win_onehot;
            O_TX_START <= 1'b1;
            O_OWNER    <= win;
            ptr        <= win;
            O_BUSY     <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (done_ok) begin
            state  <= IDLE;
            O_BUSY <= 1'b0;
          end else if (wd_hit) begin
            state     <= IDLE;
            O_BUSY    <= 1'b0;
            O_TIMEOUT <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
// Define UART_ARB_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'h0;
  logic [31:0] data = 32'h0;
  logic        tx_done = 1'b0;
  logic [3:0]  gnt;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic [3:0]  owner;
  logic        timeout;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(100)) dut (
    .I_CLK(clk), .I_RSTF(rst_n), .I_REQ(req), .I_DATA(data),
    .O_GNT(gnt), .O_TX_START(tx_start), .O_TX_DATA(tx_data),
    .I_TX_DONE(tx_done), .O_BUSY(busy), .O_OWNER(owner), .O_TIMEOUT(timeout)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [7:0] b; } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, start_cnt = 0, start_cyc = 0, done_cyc = 0;
  int to_cnt = 0, to_cyc = 0, m_ptr = N - 1;
  logic to_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference round-robin pick: push the expected winner and its byte.
  task automatic push_pick(input logic [3:0] mask);
    int w;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      if (w < 0 && mask[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    end
    if (w >= 0) begin
      exp_q.push_back('{idx: w, b: data[8*w +: 8]});
      m_ptr = w;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (tx_start) begin
      start_cnt++;
      start_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_start", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("gnt", 32'(gnt), 32'(1) << e.idx);
        check("tx_data", 32'(tx_data), 32'(e.b));
        check("owner", 32'(owner), e.idx);
        check("busy_at_start", 32'(busy), 32'd1);
      end
    end else if (gnt != 4'h0) begin
      check("gnt_without_start", 32'(gnt), 32'd0);
    end
    if (timeout) begin
      to_cnt++;
      to_cyc  = cyc;
      to_busy = busy;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k;
    k = 0;
    while (start_cnt < target && k < budget) begin
      step();
      k++;
    end
    if (start_cnt < target) check("start_wait_expired", 32'(start_cnt), 32'(target));
  endtask

  task automatic pulse_done();
    tx_done  = 1'b1;
    done_cyc = cyc;
    step();
    tx_done  = 1'b0;
  endtask

  initial begin
    int rel, s, k;
    // Reset with all requests pending
    rst_n = 1'b0;
    req   = 4'hF;
    data  = 32'h44332211;
    step(3);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    repeat (5) push_pick(4'hF);
    rst_n = 1'b1;
    rel   = cyc;
    wait_starts(1, 5);
    check("rst_to_start", 32'(start_cyc - rel), 32'd1);

    // Round-robin with all requesters held
    for (int g = 1; g <= 5; g++) begin
      if (g > 1) begin
        wait_starts(g, 10);
        check("done_to_start", 32'(start_cyc - done_cyc), 32'd2);
      end
      if (g == 5) req = 4'h0;
      step(20);
      pulse_done();
    end
    step(3);
    check("rr_start_count", 32'(start_cnt), 32'd5);

    // Sole requester re-granted each transfer
    data = 32'h00A50000;
    req  = 4'b0100;
    repeat (3) push_pick(4'b0100);
    for (int g = 1; g <= 3; g++) begin
      wait_starts(5 + g, 6);
      if (g == 3) req = 4'h0;
      step(5);
      pulse_done();
    end
    step(3);
    check("sparse_start_count", 32'(start_cnt), 32'd8);

    // Stale done in START cycle, then done while idle
    data = 32'h00003C00;
    req  = 4'b0010;
    push_pick(4'b0010);
    wait_starts(9, 6);
    req = 4'h0;
    pulse_done();
    step(2);
    check("busy_after_stale", 32'(busy), 32'd1);
    pulse_done();
    step();
    check("busy_after_done", 32'(busy), 32'd0);
    pulse_done();
    step(2);
    check("busy_idle_done", 32'(busy), 32'd0);
    check("idle_done_no_start", 32'(start_cnt), 32'd9);

    // Reset in the middle of WAIT
    data = 32'h7E000081;
    req  = 4'b1000;
    push_pick(4'b1000);
    wait_starts(10, 6);
    step(3);
    check("busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req   = 4'b1001;
    step();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_owner", 32'(owner), 32'd0);
    check("midrst_gnt", 32'(gnt), 32'd0);
    m_ptr = N - 1;
    push_pick(4'b1001);
    push_pick(4'b1000);
    step(2);
    rst_n = 1'b1;
    wait_starts(11, 6);
    req = 4'b1000;
    step(4);
    pulse_done();
    wait_starts(12, 6);
    check("midrst_gap", 32'(start_cyc - done_cyc), 32'd2);
    req = 4'h0;
    step(4);
    pulse_done();
    step(3);

    // Transmitter never answers
    data = 32'h00005AC3;
    req  = 4'b0011;
    push_pick(4'b0011);
    push_pick(4'b0010);
    wait_starts(13, 6);
    s   = start_cyc;
    req = 4'b0010;
`ifdef UART_ARB_TIMEOUT_EN
    k = 0;
    while (to_cnt == 0 && k < 150) begin
      step();
      k++;
    end
    check("timeout_seen", 32'(to_cnt), 32'd1);
    check("timeout_delay", 32'(to_cyc - s), 32'd100);
    check("busy_at_timeout", 32'(to_busy), 32'd0);
    wait_starts(14, 6);
    check("timeout_to_start", 32'(start_cyc - to_cyc), 32'd1);
`else
    step(150);
    check("busy_held", 32'(busy), 32'd1);
    check("no_timeout", 32'(to_cnt), 32'd0);
    check("start_held", 32'(start_cnt), 32'd13);
    pulse_done();
    wait_starts(14, 6);
`endif
    req = 4'h0;
    step(3);
    pulse_done();
    step(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef UART_ARB_TIMEOUT_EN
    check("timeout_total", 32'(to_cnt), 32'd1);
`else
    check("timeout_total", 32'(to_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
